// File: rtl/pwm_duty_capture.sv
// pwm_duty_capture
//   Decodes an asynchronous PWM waveform into a duty figure (high cycles in a
//   255-cycle window), a period figure (clocks between accepted rising edges)
//   and a stale flag (no accepted rising edge for 65535 enabled cycles).
//
// Ports
//   clk     in   single clock, rising edge
//   rst_n   in   synchronous active-low reset (dominant over ena)
//   ena     in   measurement enable; low freezes window/period counters
//   pwm_in  in   asynchronous PWM input
//   duty    out  [7:0]  high-cycle count of the last completed window
//   period  out  [15:0] clocks between the last two accepted rising edges
//   valid   out  one-cycle strobe when duty is updated
//   stale   out  high while no accepted rising edge for 65535 cycles

module pwm_duty_capture #(
    parameter int FILT_LEN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        pwm_in,
    output logic [7:0]  duty,
    output logic [15:0] period,
    output logic        valid,
    output logic        stale
);

    // Run counter value at which the next mismatching sample flips f.
    localparam logic [2:0] RUN_LAST = 3'(FILT_LEN - 1);
    localparam logic [7:0] WIN_LAST = 8'd254;
    localparam logic [15:0] PC_MAX  = 16'hFFFF;

    logic        sync_a;
    logic        s;
    logic        f;
    logic        f_d;
    logic [2:0]  run;
    logic [7:0]  win;
    logic [7:0]  acc;
    logic [15:0] pc;
    logic        armed;

    logic        rise;
    logic [15:0] pc_inc;

    // Accepted rising edge: filtered level went 0 -> 1 on the previous edge.
    assign rise   = f & ~f_d;
    assign pc_inc = (pc == PC_MAX) ? pc : pc + 16'd1;

    // Synchronizer and glitch filter keep running regardless of ena.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            s      <= 1'b0;
            f      <= 1'b0;
            f_d    <= 1'b0;
            run    <= '0;
        end else begin
            sync_a <= pwm_in;
            s      <= sync_a;
            f_d    <= f;
            if (s != f) begin
                if (run == RUN_LAST) begin
                    f   <= ~f;
                    run <= '0;
                end else begin
                    run <= run + 3'd1;
                end
            end else begin
                // A mismatch run shorter than FILT_LEN is a glitch; forget it.
                run <= '0;
            end
        end
    end

    // 255-cycle duty window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win   <= '0;
            acc   <= '0;
            duty  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (ena) begin
                if (win == WIN_LAST) begin
                    // acc holds at most 254 here, so adding f cannot wrap.
                    duty  <= acc + {7'd0, f};
                    acc   <= '0;
                    win   <= '0;
                    valid <= 1'b1;
                end else begin
                    acc <= acc + {7'd0, f};
                    win <= win + 8'd1;
                end
            end
        end
    end

    // Period measurement and stale detection; independent of the window path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= '0;
            armed  <= 1'b0;
            period <= '0;
            stale  <= 1'b0;
        end else if (ena) begin
            if (rise) begin
                pc    <= 16'd1;
                armed <= 1'b1;
                stale <= 1'b0;
                // The first edge after reset only arms the measurement.
                if (armed) begin
                    period <= pc;
                end
            end else begin
                pc <= pc_inc;
                if (pc_inc == PC_MAX) begin
                    stale  <= 1'b1;
                    period <= '0;
                end
            end
        end
    end

endmodule
